// File: rtl/climate_pkg.sv
// Shared types and the code-folding helper for the climate trend monitor.
// Classifier codes outside SNOW..ERROR are treated as ERROR downstream.
package climate_pkg;

  typedef enum logic [31:0] {
    UNDEFINED = 32'd0,
    SNOW      = 32'd1,
    SUNNY     = 32'd2,
    STORM     = 32'd3,
    ERROR     = 32'd4
  } climate_t;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    WATCH   = 2'd1,
    ALERT   = 2'd2,
    RECOVER = 2'd3
  } alert_state_t;

  // UNDEFINED and any out-of-range code fold to ERROR.
  function automatic climate_t map_condition(input logic [31:0] code);
    climate_t res;
    if ((code >= 32'd1) && (code <= 32'd4)) begin
      res = climate_t'(code);
    end else begin
      res = ERROR;
    end
    return res;
  endfunction

endpackage

// File: rtl/climate_trend_monitor_if.sv
// Result stream from the climate classifier: one-cycle done strobe plus class code.
interface climate_trend_monitor_if;
  logic        done;
  logic [31:0] climate_condition;

  modport master (output done, output climate_condition);
  modport slave  (input  done, input  climate_condition);
endinterface

// File: rtl/sat_counter.sv
// Registered saturating counter; a clear takes effect before a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear-then-increment, holding at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1'b1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/climate_trend_monitor.sv
// Per-class statistics, run length, storm-alert hysteresis FSM and sticky
// sensor-fault flag over the classifier's done/climate_condition stream.
module climate_trend_monitor
  import climate_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int STORM_ALERT_LEN = 3,
  parameter int CLEAR_LEN       = 2,
  parameter int FAULT_LEN       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  climate_trend_monitor_if.slave sample_if,
  input  logic                 clear_stats,
  output logic [31:0]          last_condition,
  output logic                 condition_changed,
  output logic [CNT_W-1:0]     run_length,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     snow_count,
  output logic [CNT_W-1:0]     sunny_count,
  output logic [CNT_W-1:0]     storm_count,
  output logic [CNT_W-1:0]     error_count,
  output logic [1:0]           alert_state,
  output logic                 storm_alert,
  output logic                 alert_pulse,
  output logic                 sensor_fault
);

  localparam logic [31:0] ALERT_LEN_C = 32'(STORM_ALERT_LEN);
  localparam logic [31:0] CLEAR_LEN_C = 32'(CLEAR_LEN);
  localparam logic [31:0] FAULT_LEN_C = 32'(FAULT_LEN);

  logic         done_s;
  climate_t     mapped_s;
  logic         is_storm_s;
  logic         is_err_s;
  logic         changed_s;
  logic [CNT_W-1:0] err_run_next_s;

  climate_t     last_q;
  logic         changed_q;
  logic         fault_q;
  logic         fault_d;

  alert_state_t state_q;
  logic [31:0]  storm_run_q;
  logic [31:0]  calm_run_q;
  logic         storm_alert_q;
  logic         alert_pulse_q;

  assign done_s     = sample_if.done;
  assign mapped_s   = map_condition(sample_if.climate_condition);
  assign is_storm_s = (mapped_s == STORM);
  assign is_err_s   = (mapped_s == ERROR);
  // A same-cycle clear resets last_condition to UNDEFINED, which no mapped class equals.
  assign changed_s  = clear_stats | (mapped_s != last_q);

  sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear_stats),
    .inc(done_s), .cnt(sample_count)
  );
  sat_counter #(.W(CNT_W)) u_snow_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear_stats),
    .inc(done_s && (mapped_s == SNOW)), .cnt(snow_count)
  );
  sat_counter #(.W(CNT_W)) u_sunny_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear_stats),
    .inc(done_s && (mapped_s == SUNNY)), .cnt(sunny_count)
  );
  sat_counter #(.W(CNT_W)) u_storm_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear_stats),
    .inc(done_s && is_storm_s), .cnt(storm_count)
  );
  sat_counter #(.W(CNT_W)) u_error_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear_stats),
    .inc(done_s && is_err_s), .cnt(error_count)
  );
  sat_counter #(.W(CNT_W)) u_run_len (
    .clk(clk), .rst_n(rst_n), .clr(clear_stats | (done_s & changed_s)),
    .inc(done_s), .cnt(run_length)
  );

  // Run length the accepted sample will produce, used for the fault threshold.
  always_comb begin
    err_run_next_s = run_length;
    if (changed_s) begin
      err_run_next_s = CNT_W'(1'b1);
    end else if (run_length == '1) begin
      err_run_next_s = run_length;
    end else begin
      err_run_next_s = run_length + CNT_W'(1'b1);
    end
  end

  // Sticky fault; a clear beats a threshold-reaching sample unless one ERROR suffices.
  always_comb begin
    fault_d = fault_q;
    if (clear_stats) begin
      fault_d = done_s && is_err_s && (FAULT_LEN_C == 32'd1);
    end else if (done_s && is_err_s && (32'(err_run_next_s) >= FAULT_LEN_C)) begin
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end
  end

  // Last accepted class, change pulse and fault register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= UNDEFINED;
      changed_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      changed_q <= done_s & changed_s;
      fault_q   <= fault_d;
      if (done_s) begin
        last_q <= mapped_s;
      end else if (clear_stats) begin
        last_q <= UNDEFINED;
      end
    end
  end

  // Storm-alert FSM with hysteresis; clear_stats deliberately has no effect here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= NORMAL;
      storm_run_q   <= 32'd0;
      calm_run_q    <= 32'd0;
      storm_alert_q <= 1'b0;
      alert_pulse_q <= 1'b0;
    end else begin
      alert_pulse_q <= 1'b0;
      if (done_s) begin
        case (state_q)
          NORMAL: begin
            if (is_storm_s) begin
              state_q     <= WATCH;
              storm_run_q <= 32'd1;
            end
          end
          WATCH: begin
            if (!is_storm_s) begin
              state_q <= NORMAL;
            end else if ((storm_run_q + 32'd1) == ALERT_LEN_C) begin
              state_q       <= ALERT;
              storm_alert_q <= 1'b1;
              alert_pulse_q <= 1'b1;
            end else begin
              storm_run_q <= storm_run_q + 32'd1;
            end
          end
          ALERT: begin
            if (!is_storm_s) begin
              state_q    <= RECOVER;
              calm_run_q <= 32'd1;
            end
          end
          RECOVER: begin
            if (is_storm_s) begin
              state_q <= ALERT;
            end else if ((calm_run_q + 32'd1) == CLEAR_LEN_C) begin
              state_q       <= NORMAL;
              storm_alert_q <= 1'b0;
            end else begin
              calm_run_q <= calm_run_q + 32'd1;
            end
          end
          default: begin
            state_q       <= NORMAL;
            storm_alert_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign last_condition    = last_q;
  assign condition_changed = changed_q;
  assign alert_state       = state_q;
  assign storm_alert       = storm_alert_q;
  assign alert_pulse       = alert_pulse_q;
  assign sensor_fault      = fault_q;

endmodule
